exe_unit_arbiter: RTL and testbench
===================================

Name: exe_unit_arbiter

Overview:
- Shares one execution unit (subtract / compare / shift / bit-change, 2-bit op code, BITS-wide operands, 4-bit status) between NREQ requesters.
- Accepts one request at a time via valid/ready, drives the execution-unit operand and op ports, waits the unit's latency, then returns result, status and requester ID on a single response channel.
- Sits between the requester ports and the execution-unit instance. The execution unit is instantiated outside this block and connected through the o_exe_* / i_exe_* ports.

Parameters:
- BITS, 8, operand and result width.
- NREQ, 4, number of requesters (≥2).
- IDW, $clog2(NREQ), requester ID width (derived; do not override).
- EXE_LAT, 1, execution-unit register latency in cycles (≥1).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset; asynchronous assert, active-low.
- i_req_valid  in  NREQ  per-requester request valid.
- i_req_a  in  NREQ*BITS  operand A; requester k occupies bits [k*BITS +: BITS].
- i_req_b  in  NREQ*BITS  operand B, same packing as i_req_a.
- i_req_op  in  NREQ*2  op code, 2 bits per requester.
- o_req_ready  out  NREQ  one-hot grant/accept.
- o_exe_a  out  BITS  operand A to the execution unit.
- o_exe_b  out  BITS  operand B to the execution unit.
- o_exe_op  out  2  op code to the execution unit.
- i_exe_out  in  BITS  execution-unit result.
- i_exe_status  in  4  execution-unit status flags.
- o_rsp_valid  out  1  response valid.
- o_rsp_id  out  IDW  index of the requester that owns the response.
- o_rsp_data  out  BITS  captured result.
- o_rsp_status  out  4  captured status, passed through unmodified.
- i_rsp_ready  in  1  response consumer ready.
- o_busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - state=IDLE; all registered outputs 0 (o_exe_*, o_rsp_*, o_busy).
  - RR pointer=NREQ-1, so requester 0 wins first.
- Reset mid-operation: the in-flight op is discarded, no response is produced, and the block returns to IDLE.
- FSM states: IDLE → EXEC → RESP → IDLE.
- IDLE:
  - o_req_ready[g]=1 combinationally for the granted g only when i_req_valid≠0; otherwise all zero.
  - g is the first valid index searching from pointer+1 upward, wrapping modulo NREQ.
  - On the edge: latch A, B and op of g into the o_exe_* registers; o_rsp_id←g; pointer←g; clear latency counter; go to EXEC.
- Requester rule: once valid is asserted, hold valid and data stable until ready. Dropping valid without ready is legal and simply cancels.
- EXEC:
  - o_exe_* held constant for the whole state.
  - Lasts exactly EXE_LAT+1 cycles, counted by the latency counter.
  - On the last cycle's edge: o_rsp_data←i_exe_out, o_rsp_status←i_exe_status; go to RESP.
- RESP:
  - o_rsp_valid=1; data, status and ID held stable.
  - On an edge with i_rsp_ready=1: o_rsp_valid←0; go to IDLE.
  - With i_rsp_ready=0: stall indefinitely; o_req_ready stays 0.
- Latency (EXE_LAT=1):
  - o_rsp_valid rises 2 edges after the accepting edge.
  - Peak throughput is 1 op per EXE_LAT+3 cycles (with i_rsp_ready held high).
- Simultaneous requests: exactly one grant per IDLE cycle. Non-granted requesters keep waiting.
- Single requester continuously valid: served every round; pointer wrap causes no starvation or skip.
- No arithmetic in this block; flags are never recomputed.
- o_exe_* keep their last values after the response completes; they return to 0 only on reset.

Optional Feature:
- Macro: EXE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest valid index always wins and the pointer is unused (held at reset value).
- Undefined (default): round-robin as described above.
- Port list and timing are identical in both builds.

Test Plan:
- Reset, single requester:
  - Hold i_rst=0 for 3 cycles, release; req0 valid, op=00, a=91, b=41.
  - Expect: ready0 for 1 cycle; o_exe_a=91, o_exe_b=41, o_exe_op=00 the next cycle; o_rsp_valid 2 edges after accept, data=50, id=0, status equal to the model's status.
- All four valid, i_rsp_ready=1:
  - Grants in order 0,1,2,3,0; accept-to-accept spacing 4 cycles.
  - With EXE_ARB_FIXED_PRIO_EN defined, only requester 0 is granted while it stays valid.
- Response backpressure:
  - i_rsp_ready=0 for 10 cycles during RESP.
  - Expect: o_rsp_valid, data and ID stable; all o_req_ready=0; resume when ready=1.
- Reset mid-EXEC:
  - Pull i_rst low during EXEC.
  - Expect: all outputs 0 immediately (asynchronously); no response after release; pointer back to NREQ-1.
- Op coverage:
  - Requesters 1 and 2 issue op=01 (a=50, b=50) and op=11 (a=0x66, b=3).
  - Expect: each response data and status match a reference execution-unit model; IDs 1 and 2.
- Valid withdrawn:
  - req3 asserts valid for one cycle while busy, then drops it.
  - Expect: req3 is never granted and produces no response.

Source files
------------

// File: rtl/exe_unit_arbiter.sv
// rtl/exe_unit_arbiter.sv - shares one external execution unit between NREQ requesters
//
// Purpose:
//   Accepts one request at a time from NREQ requesters (valid/ready), forwards its
//   operands and op code to an external execution unit, waits the unit's latency,
//   and returns result, status and requester ID on a single response channel.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-low reset
//   i_req_valid/a/b/op    packed per-requester request fields (requester k at [k*W +: W])
//   o_req_ready           one-hot accept, combinational, IDLE only
//   o_exe_a/b/op          registered operands/op to the execution unit
//   i_exe_out/status      execution-unit result and flags
//   o_rsp_valid/id/data/status, i_rsp_ready   response channel
//   o_busy                high whenever the FSM is not idle
//
// Build option:
//   EXE_ARB_FIXED_PRIO_EN  lowest valid index always wins; RR pointer stays at reset value.

module exe_unit_arbiter #(
    parameter int BITS    = 8,
    parameter int NREQ    = 4,
    localparam int IDW    = $clog2(NREQ),
    parameter int EXE_LAT = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [NREQ*BITS-1:0] i_req_a,
    input  logic [NREQ*BITS-1:0] i_req_b,
    input  logic [NREQ*2-1:0]    i_req_op,
    output logic [NREQ-1:0]      o_req_ready,
    output logic [BITS-1:0]      o_exe_a,
    output logic [BITS-1:0]      o_exe_b,
    output logic [1:0]           o_exe_op,
    input  logic [BITS-1:0]      i_exe_out,
    input  logic [3:0]           i_exe_status,
    output logic                 o_rsp_valid,
    output logic [IDW-1:0]       o_rsp_id,
    output logic [BITS-1:0]      o_rsp_data,
    output logic [3:0]           o_rsp_status,
    input  logic                 i_rsp_ready,
    output logic                 o_busy
);

    localparam int CW = $clog2(EXE_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [CW-1:0]   lat_cnt;
    logic            grant_found;
    logic [IDW-1:0]  grant_idx;

    // Grant selection. Round-robin searches upward from the slot after the last
    // winner so a continuously valid requester can never be skipped on wrap.
    always_comb begin
        int j;
        grant_found = 1'b0;
        grant_idx   = '0;
        j           = 0;
`ifdef EXE_ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(i);
            end
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!grant_found && i_req_valid[j]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(j);
            end
        end
`endif
    end

    assign o_req_ready = (state == IDLE && grant_found) ? (NREQ'(1) << grant_idx) : '0;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state        <= IDLE;
            ptr          <= IDW'(NREQ - 1);
            lat_cnt      <= '0;
            o_exe_a      <= '0;
            o_exe_b      <= '0;
            o_exe_op     <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_id     <= '0;
            o_rsp_data   <= '0;
            o_rsp_status <= '0;
            o_busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        o_exe_a  <= i_req_a[grant_idx*BITS +: BITS];
                        o_exe_b  <= i_req_b[grant_idx*BITS +: BITS];
                        o_exe_op <= i_req_op[grant_idx*2 +: 2];
                        o_rsp_id <= grant_idx;
`ifndef EXE_ARB_FIXED_PRIO_EN
                        ptr      <= grant_idx;
`endif
                        lat_cnt  <= '0;
                        o_busy   <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    // EXE_LAT+1 cycles: operands settle into the unit's input
                    // registers, then its output register is sampled.
                    if (lat_cnt == CW'(EXE_LAT)) begin
                        o_rsp_data   <= i_exe_out;
                        o_rsp_status <= i_exe_status;
                        o_rsp_valid  <= 1'b1;
                        state        <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_unit_arbiter.sv
// tb/tb_exe_unit_arbiter.sv - directed self-checking bench for exe_unit_arbiter
module tb_exe_unit_arbiter;

    localparam int BITS = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 i_clk = 1'b0;
    logic                 i_rst = 1'b0;
    logic [NREQ-1:0]      i_req_valid = '0;
    logic [NREQ*BITS-1:0] i_req_a = '0;
    logic [NREQ*BITS-1:0] i_req_b = '0;
    logic [NREQ*2-1:0]    i_req_op = '0;
    logic [NREQ-1:0]      o_req_ready;
    logic [BITS-1:0]      o_exe_a;
    logic [BITS-1:0]      o_exe_b;
    logic [1:0]           o_exe_op;
    logic [BITS-1:0]      i_exe_out = '0;
    logic [3:0]           i_exe_status = '0;
    logic                 o_rsp_valid;
    logic [IDW-1:0]       o_rsp_id;
    logic [BITS-1:0]      o_rsp_data;
    logic [3:0]           o_rsp_status;
    logic                 i_rsp_ready = 1'b1;
    logic                 o_busy;

    int tests_run = 0;
    int fails     = 0;

    exe_unit_arbiter #(.BITS(BITS), .NREQ(NREQ), .EXE_LAT(1)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_op(i_req_op),
        .o_req_ready(o_req_ready),
        .o_exe_a(o_exe_a), .o_exe_b(o_exe_b), .o_exe_op(o_exe_op),
        .i_exe_out(i_exe_out), .i_exe_status(i_exe_status),
        .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_data(o_rsp_data),
        .o_rsp_status(o_rsp_status), .i_rsp_ready(i_rsp_ready), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Reference execution unit, one register stage.
    // status = {zero, borrow/old-bit, msb, lsb}
    function automatic logic [11:0] exe_model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        logic [7:0] r;
        logic       c;
        case (op)
            2'b00:   begin r = a - b;                   c = (a < b);  end
            2'b01:   begin r = {7'b0, (a < b)};         c = (a < b);  end
            2'b10:   begin r = a << b[2:0];             c = 1'b0;     end
            default: begin r = a ^ (8'h01 << b[2:0]);   c = a[b[2:0]]; end
        endcase
        return {(r == 8'h00), c, r[7], r[0], r};
    endfunction

    always @(posedge i_clk) {i_exe_status, i_exe_out} <= exe_model(o_exe_a, o_exe_b, o_exe_op);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        i_req_a[k*BITS +: BITS] = a;
        i_req_b[k*BITS +: BITS] = b;
        i_req_op[k*2 +: 2]      = op;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!o_rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check(tag, o_rsp_valid, 1);
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        #1;
        while (o_req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        check(tag, (o_req_ready != '0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_seq[5];
        int exp_data[4];
        int exp_stat[4];
        int g_n, r_n, last_c;
        logic [7:0]     hold_data;
        logic [IDW-1:0] hold_id;

        // ---- reset and single requester
        repeat (3) tick();
        check("rst_busy", o_busy, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_exe_a", o_exe_a, 0);
        check("rst_exe_op", o_exe_op, 0);
        check("rst_rsp_data", o_rsp_data, 0);
        i_rst = 1'b1;
        tick();
        check("idle_ready_none", o_req_ready, 0);
        set_req(0, 8'd91, 8'd41, 2'b00);
        i_req_valid = 4'b0001;
        #1;
        check("t1_ready0", o_req_ready, 4'b0001);
        tick();
        i_req_valid = '0;
        #1;
        check("t1_ready_after", o_req_ready, 0);
        check("t1_exe_a", o_exe_a, 91);
        check("t1_exe_b", o_exe_b, 41);
        check("t1_exe_op", o_exe_op, 0);
        check("t1_busy", o_busy, 1);
        check("t1_rsp_early0", o_rsp_valid, 0);
        tick();
        check("t1_rsp_early1", o_rsp_valid, 0);
        tick();
        check("t1_rsp_valid", o_rsp_valid, 1);
        check("t1_rsp_data", o_rsp_data, 50);
        check("t1_rsp_id", o_rsp_id, 0);
        check("t1_rsp_status", o_rsp_status, 4'b0000);
        tick();
        check("t1_rsp_done", o_rsp_valid, 0);
        check("t1_idle", o_busy, 0);
        check("t1_exe_hold", o_exe_a, 91);

        // ---- all four valid, responses always accepted
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
`ifdef EXE_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 2, 3, 0};
`endif
        exp_data = '{20, 35, 50, 65};
        exp_stat = '{0, 1, 0, 1};
        for (int k = 0; k < NREQ; k++) set_req(k, 8'(20 + 16 * k), 8'(k), 2'b00);
        i_req_valid = 4'b1111;
        #1;
        g_n = 0;
        r_n = 0;
        last_c = 0;
        for (int c = 0; c < 40 && r_n < 5; c++) begin
            if (o_req_ready != '0) begin
                check("rr_grant", o_req_ready, 4'b0001 << exp_seq[g_n]);
                if (g_n > 0) check("rr_spacing", c - last_c, 4);
                last_c = c;
                g_n++;
            end
            if (o_rsp_valid) begin
                check("rr_rsp_id", o_rsp_id, exp_seq[r_n]);
                check("rr_rsp_data", o_rsp_data, exp_data[exp_seq[r_n]]);
                check("rr_rsp_status", o_rsp_status, exp_stat[exp_seq[r_n]]);
                r_n++;
            end
            tick();
            if (g_n == 5) i_req_valid = '0;
        end
        check("rr_grant_count", g_n, 5);
        check("rr_rsp_count", r_n, 5);

        // ---- response backpressure
        i_rsp_ready = 1'b0;
        i_req_valid = 4'b0011;
        wait_grant("bp_grant");
        tick();
        wait_rsp("bp_rsp");
        hold_data = o_rsp_data;
        hold_id   = o_rsp_id;
`ifdef EXE_ARB_FIXED_PRIO_EN
        check("bp_id", o_rsp_id, 0);
        check("bp_data", o_rsp_data, 20);
`else
        check("bp_id", o_rsp_id, 1);
        check("bp_data", o_rsp_data, 35);
`endif
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_valid_hold", o_rsp_valid, 1);
            check("bp_data_hold", o_rsp_data, hold_data);
            check("bp_id_hold", o_rsp_id, hold_id);
            check("bp_ready_low", o_req_ready, 0);
        end
        i_rsp_ready = 1'b1;
        tick();
        check("bp_released", o_rsp_valid, 0);
        check("bp_next_grant", o_req_ready, 4'b0001);
        i_req_valid = '0;   // cancel before the edge
        tick();
        check("bp_cancel_idle", o_busy, 0);

        // ---- reset during EXEC (req0 accepted, so a stale pointer would favour req1)
        i_req_valid = 4'b0001;
        tick();
        i_req_valid = '0;
        check("mr_busy", o_busy, 1);
        tick();
        i_rst = 1'b0;
        #1;
        check("mr_busy_clr", o_busy, 0);
        check("mr_exe_a_clr", o_exe_a, 0);
        check("mr_exe_b_clr", o_exe_b, 0);
        check("mr_rsp_valid_clr", o_rsp_valid, 0);
        check("mr_rsp_data_clr", o_rsp_data, 0);
        tick();
        i_rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("mr_no_rsp", o_rsp_valid, 0);
        end
        i_req_valid = 4'b0011;
        #1;
        check("mr_ptr_reset", o_req_ready, 4'b0001);
        i_req_valid = '0;
        tick();

        // ---- op coverage: req1 compare, req2 bit-change (pointer at NREQ-1)
        set_req(1, 8'd50, 8'd50, 2'b01);
        set_req(2, 8'h66, 8'd3, 2'b11);
        i_req_valid = 4'b0110;
        #1;
        check("op_grant1", o_req_ready, 4'b0010);
        tick();
        i_req_valid = 4'b0100;
        wait_rsp("op_rsp1");
        check("op_id1", o_rsp_id, 1);
        check("op_data1", o_rsp_data, 8'h00);
        check("op_status1", o_rsp_status, 4'b1000);
        tick();
        check("op_grant2", o_req_ready, 4'b0100);
        tick();
        i_req_valid = '0;
        wait_rsp("op_rsp2");
        check("op_id2", o_rsp_id, 2);
        check("op_data2", o_rsp_data, 8'h6E);
        check("op_status2", o_rsp_status, 4'b0000);
        tick();

        // ---- req3 valid for one busy cycle, then withdrawn
        set_req(0, 8'd91, 8'd41, 2'b00);
        set_req(3, 8'hAA, 8'h01, 2'b10);
        i_req_valid = 4'b0001;
        #1;
        check("wd_grant0", o_req_ready, 4'b0001);
        tick();
        i_req_valid = 4'b1000;
        #1;
        check("wd_ready_busy", o_req_ready, 0);
        tick();
        i_req_valid = '0;
        wait_rsp("wd_rsp");
        check("wd_rsp_id", o_rsp_id, 0);
        check("wd_rsp_data", o_rsp_data, 50);
        tick();
        for (int c = 0; c < 6; c++) begin
            check("wd_no_grant", o_req_ready, 0);
            check("wd_no_rsp", o_rsp_valid, 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
